inst_loader_mem: RTL and testbench
==================================

# inst_loader_mem

Instruction memory and program loader on the fetch side of the single-cycle core. It receives a program over a byte-serial valid/ready stream and writes it into a word-addressed instruction RAM. While loading, it holds the core in reset. Once loading completes, it serves the instruction word at the core's word-indexed PC combinationally.

## Interface
- `DEPTH`, default 256: number of 32-bit instruction words.
- `AW`, default 8: address width; `DEPTH == 2**AW`.
- `NOP`, default 32'h00000013: word returned for unloaded or out-of-range addresses.

Ports (clock and reset first):
- `i_clk`  in  1: single clock; all state changes on its rising edge.
- `i_rst`  in  1: synchronous, active-high reset.
- `i_byte`  in  8: load stream data byte.
- `i_byte_valid`  in  1: `i_byte` is valid this cycle.
- `o_byte_ready`  out  1: loader accepts a byte this cycle.
- `i_reload`  in  1: request a new program load (honoured only in RUN).
- `i_pc`  in  32: core fetch address, word index (PC increments by 1 per instruction).
- `o_inst`  out  32: instruction for `i_pc`, combinational.
- `o_core_rst`  out  1: registered, active-high reset to the core.
- `o_err`  out  1: registered sticky length error.
- `o_words`  out  16: registered count of words in the current program.

## Operation
- **Handshake:** a byte is accepted on a cycle where `i_byte_valid && o_byte_ready`. `o_byte_ready = 1` in LEN0, LEN1 and DATA; it is 0 in RUN and ERR. It is decoded from state only and never depends on `i_byte_valid`.
- **Stream format:** little-endian 16-bit word count N (LEN0 takes the low byte, LEN1 the high byte), followed by N×4 bytes. Each word is little-endian: the first byte goes to bits [7:0].
- **States:**
  - LEN0: on accept, latch the low byte of N, then go to LEN1.
  - LEN1: on accept, form N.
    - N == 0 → RUN.
    - N > DEPTH → ERR.
    - Otherwise → DATA with `wptr = 0`, `bcnt = 0`.
  - DATA: on each accept, shift the byte into the assembly register and increment `bcnt` (2 bits, wraps).
    - On the 4th byte, write the assembled word to `mem[wptr]` that same edge and increment `wptr`.
    - When `wptr` reaches N-1 and the 4th byte is accepted → RUN.
  - RUN: `o_core_rst = 0`. If `i_reload == 1` → LEN0, `o_core_rst = 1`, `o_words = 0`.
  - ERR: `o_err = 1`, `o_core_rst = 1`. The only exit is `i_rst`.
- **`o_words`:** updated to N on the LEN1 accept when N ≤ DEPTH.
- **Fetch decode:**
  - `o_inst = mem[i_pc[AW-1:0]]` when `i_pc < o_words`, with the comparison done in 32 bits (upper bits of `i_pc` count).
  - Otherwise `o_inst = NOP`. A branch past the program therefore executes NOPs and the PC keeps walking.
- **No memory clear:** the RAM is never cleared. Stale words above `o_words` are masked by the compare.
- **Read during write:** returns the old data. This cannot be observed by the core because the core is held in reset during DATA.
- **`i_valid` while not ready:** `i_byte_valid` asserted in RUN or ERR is ignored and has no side effect.

## Timing
- **Reset values** (cycle after `i_rst` is sampled high): state LEN0, `o_byte_ready = 1`, `o_core_rst = 1`, `o_err = 0`, `o_words = 0`, `wptr = 0`, `bcnt = 0`. `o_inst = NOP` for every `i_pc`.
- **Reset mid-load:** `i_rst` asserted in DATA discards the partial program. `o_words = 0`, so every fetch returns NOP.
- **Load throughput:** one byte per cycle sustained. Gaps in `i_byte_valid` stall the loader without penalty.
- **Completion latency:** final byte accepted at edge k → at edge k the word is written and state goes to RUN, so `o_core_rst` reads 0 after edge k. The core's first un-reset edge is k+1, and it fetches `i_pc = 0`.
- **Reload:** `i_reload` sampled in RUN at edge k → after edge k, `o_core_rst = 1` and `o_byte_ready = 1`. A byte presented in the same cycle as `i_reload` is not accepted.
- **Error latency:** ERR entry is visible on `o_err` the cycle after the LEN1 accept.
- **Fetch latency:** `o_inst` is combinational from `i_pc`, with zero cycles latency, matching the single-cycle core.

## Test plan
1. **Basic load:** after reset, stream 02 00, then 93 00 50 00 (addi x1,x0,5), then 37 51 34 12.
   - After the last accept: `o_core_rst = 0`, `o_words = 2`.
   - `i_pc = 0` → 32'h00500093; `i_pc = 1` → 32'h12345137; `i_pc = 2` → 32'h00000013.
2. **Stalled stream:** the same program with `i_byte_valid` toggling 1,0,0,1 per cycle → identical memory contents, and completion is delayed only by the idle cycles.
3. **Zero length:** stream 00 00 → RUN one cycle after the second byte; `o_inst = NOP` for `i_pc` values 0, 255 and 32'hFFFFFFFF.
4. **Overflow:** stream 01 01 (N = 257 > 256) → `o_err = 1`, `o_core_rst = 1`, `o_byte_ready = 0`. Further bytes are ignored. Asserting `i_rst` returns to LEN0 with `o_err = 0`.
5. **Reload:** after test 1, pulse `i_reload` in RUN, then stream 01 00 EF BE AD DE.
   - `o_core_rst` is high during the load.
   - Afterwards, `i_pc = 0` → 32'hDEADBEEF and `i_pc = 1` → NOP (the stale word is masked).
6. **Reset mid-load:** assert `i_rst` after 5 data bytes of a 2-word load → `o_words = 0`, `o_core_rst = 1`, state LEN0. A subsequent full load succeeds.

Source files
------------

// File: rtl/inst_loader_mem.sv
// Instruction RAM with a byte-serial program loader; holds the core in reset while loading
// and serves the word at the core's word-indexed PC combinationally once running.
module inst_loader_mem #(
  parameter int          DEPTH = 256,
  parameter int          AW    = 8,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  input  logic        i_reload,
  input  logic [31:0] i_pc,
  output logic [31:0] o_inst,
  output logic        o_core_rst,
  output logic        o_err,
  output logic [15:0] o_words
);

  typedef enum logic [2:0] {LEN0, LEN1, DATA, RUN, ERR} state_t;

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  state_t        state;
  logic [7:0]    len_lo;
  logic [23:0]   asm_q;
  logic [1:0]    bcnt;
  logic [AW-1:0] wptr;
  logic [31:0]   mem [DEPTH];

  logic        accept;
  logic [15:0] n;
  logic        word_done;
  logic        last_word;
  logic [31:0] word;

  assign o_byte_ready = (state == LEN0) || (state == LEN1) || (state == DATA);
  assign accept       = i_byte_valid && o_byte_ready;
  assign n            = {i_byte, len_lo};
  assign word         = {i_byte, asm_q};
  assign word_done    = (state == DATA) && accept && (bcnt == 2'd3);
  assign last_word    = (16'(wptr) == (o_words - 16'd1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= LEN0;
      len_lo     <= '0;
      asm_q      <= '0;
      bcnt       <= '0;
      wptr       <= '0;
      o_core_rst <= 1'b1;
      o_err      <= 1'b0;
      o_words    <= '0;
    end else begin
      case (state)
        LEN0: if (accept) begin
          len_lo <= i_byte;
          state  <= LEN1;
        end
        LEN1: if (accept) begin
          if (n == 16'd0) begin
            o_words    <= '0;
            o_core_rst <= 1'b0;
            state      <= RUN;
          end else if ({16'b0, n} > DEPTH_U) begin
            o_err <= 1'b1;
            state <= ERR;
          end else begin
            o_words <= n;
            wptr    <= '0;
            bcnt    <= '0;
            state   <= DATA;
          end
        end
        DATA: if (accept) begin
          // Bytes shift in from the top so the first byte of a word lands in bits [7:0].
          asm_q <= {i_byte, asm_q[23:8]};
          bcnt  <= bcnt + 2'd1;
          if (bcnt == 2'd3) begin
            wptr <= wptr + 1'b1;
            if (last_word) begin
              o_core_rst <= 1'b0;
              state      <= RUN;
            end
          end
        end
        RUN: if (i_reload) begin
          o_core_rst <= 1'b1;
          o_words    <= '0;
          state      <= LEN0;
        end
        ERR: begin
          o_err      <= 1'b1;
          o_core_rst <= 1'b1;
        end
        default: state <= LEN0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && word_done) mem[wptr] <= word;
  end

  // Stale RAM contents beyond the current program are masked by the 32-bit compare.
  always_comb begin
    o_inst = NOP;
    if (i_pc < {16'b0, o_words}) o_inst = mem[i_pc[AW-1:0]];
  end

endmodule

// File: tb/tb_inst_loader_mem.sv
// Directed bench for inst_loader_mem: load, stall, zero length, overflow, reload, reset mid-load.
module tb_inst_loader_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_d;
  logic        byte_valid;
  logic        byte_ready;
  logic        reload;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        core_rst;
  logic        err;
  logic [15:0] words;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] NOPW = 32'h00000013;

  inst_loader_mem #(.DEPTH(256), .AW(8), .NOP(32'h00000013)) dut (
    .i_clk(clk), .i_rst(rst), .i_byte(byte_d), .i_byte_valid(byte_valid),
    .o_byte_ready(byte_ready), .i_reload(reload), .i_pc(pc), .o_inst(inst),
    .o_core_rst(core_rst), .o_err(err), .o_words(words)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a byte for exactly one rising edge; returns at the following negedge.
  task automatic send(input logic [7:0] b);
    byte_d = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    pc = addr;
    #1;
    check(tag, inst, exp);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0] prog1 [10] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h37, 8'h51, 8'h34, 8'h12};

  initial begin
    rst = 1'b1; byte_d = '0; byte_valid = 1'b0; reload = 1'b0; pc = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_ready", 32'(byte_ready), 32'd1);
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_err", 32'(err), 32'd0);
    check("rst_words", 32'(words), 32'd0);
    fetch("rst_inst0", 32'd0, NOPW);
    fetch("rst_inst_ff", 32'hFFFFFFFF, NOPW);

    // 1. Basic load
    for (int i = 0; i < 10; i++) begin
      if (i == 9) check("t1_core_rst_before_last", 32'(core_rst), 32'd1);
      send(prog1[i]);
    end
    check("t1_core_rst", 32'(core_rst), 32'd0);
    check("t1_words", 32'(words), 32'd2);
    check("t1_ready_run", 32'(byte_ready), 32'd0);
    fetch("t1_pc0", 32'd0, 32'h00500093);
    fetch("t1_pc1", 32'd1, 32'h12345137);
    fetch("t1_pc2", 32'd2, NOPW);
    fetch("t1_pc_hi_alias", 32'h00000100, NOPW);
    // Bytes offered in RUN are ignored
    send(8'hAA); send(8'hBB);
    check("t1_ignored_words", 32'(words), 32'd2);
    fetch("t1_ignored_pc0", 32'd0, 32'h00500093);

    // 5. Reload with a single word over the old program
    do_reload();
    check("t5_core_rst", 32'(core_rst), 32'd1);
    check("t5_ready", 32'(byte_ready), 32'd1);
    check("t5_words_cleared", 32'(words), 32'd0);
    send(8'h01); send(8'h00); send(8'hEF); send(8'hBE);
    check("t5_core_rst_mid", 32'(core_rst), 32'd1);
    send(8'hAD); send(8'hDE);
    check("t5_core_rst_done", 32'(core_rst), 32'd0);
    check("t5_words", 32'(words), 32'd1);
    fetch("t5_pc0", 32'd0, 32'hDEADBEEF);
    fetch("t5_pc1_stale_masked", 32'd1, NOPW);

    // Reload byte in same cycle as i_reload is not accepted
    byte_d = 8'h00; byte_valid = 1'b1; reload = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0; reload = 1'b0;
    check("reload_byte_ignored_ready", 32'(byte_ready), 32'd1);

    // 2. Stalled stream (valid 1,0,0,1,...): only idle cycles add latency
    for (int i = 0; i < 10; i++) begin
      if (i == 9) check("t2_core_rst_before_last", 32'(core_rst), 32'd1);
      send(prog1[i]);
      if (i != 9) idle(2);
    end
    check("t2_core_rst", 32'(core_rst), 32'd0);
    check("t2_words", 32'(words), 32'd2);
    fetch("t2_pc0", 32'd0, 32'h00500093);
    fetch("t2_pc1", 32'd1, 32'h12345137);

    // 3. Zero length
    do_reload();
    send(8'h00);
    check("t3_core_rst_len1", 32'(core_rst), 32'd1);
    send(8'h00);
    check("t3_core_rst", 32'(core_rst), 32'd0);
    check("t3_words", 32'(words), 32'd0);
    fetch("t3_pc0", 32'd0, NOPW);
    fetch("t3_pc255", 32'd255, NOPW);
    fetch("t3_pc_max", 32'hFFFFFFFF, NOPW);

    // 4. Overflow: N = 257
    do_reload();
    send(8'h01); send(8'h01);
    check("t4_err", 32'(err), 32'd1);
    check("t4_core_rst", 32'(core_rst), 32'd1);
    check("t4_ready", 32'(byte_ready), 32'd0);
    send(8'h00); send(8'h00);
    do_reload();
    check("t4_err_sticky", 32'(err), 32'd1);
    check("t4_words", 32'(words), 32'd0);
    check("t4_ready_sticky", 32'(byte_ready), 32'd0);
    do_reset();
    check("t4_err_cleared", 32'(err), 32'd0);
    check("t4_ready_after_rst", 32'(byte_ready), 32'd1);

    // N == DEPTH is accepted, not an error
    send(8'h00); send(8'h01);
    check("depth_err", 32'(err), 32'd0);
    check("depth_words", 32'(words), 32'd256);
    check("depth_core_rst", 32'(core_rst), 32'd1);
    do_reset();

    // 6. Reset mid-load
    send(8'h02); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    do_reset();
    check("t6_words", 32'(words), 32'd0);
    check("t6_core_rst", 32'(core_rst), 32'd1);
    check("t6_ready", 32'(byte_ready), 32'd1);
    fetch("t6_pc0", 32'd0, NOPW);
    send(8'h01); send(8'h00); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    check("t6_reload_core_rst", 32'(core_rst), 32'd0);
    check("t6_reload_words", 32'(words), 32'd1);
    fetch("t6_reload_pc0", 32'd0, 32'h12345678);
    fetch("t6_reload_pc1", 32'd1, NOPW);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
